// File: rtl/ula_pkg.sv
// Shared constants for the sequential ULA: default width, op codes, FSM encoding.
package ula_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ula_iter.sv
// Iterative MUL/DIV datapath: one shift-add or restoring-subtract step per clock.
// hi_q holds the partial product (MUL) or remainder (DIV); lo_q holds the
// multiplier being shifted out (MUL) or the dividend/quotient shift register (DIV).
// result_next/flag_next show the value after the current step so the owner can
// register the final answer on the same edge that performs the last step.
module ula_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic             step_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result_next,
  output logic             flag_next
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic             mode_div;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_zero;

  // Next-step values for the selected algorithm.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    if (mode_div) begin
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (!div_diff[WIDTH]) begin
        hi_d = div_diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      hi_d    = mul_sum[WIDTH:1];
      lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign div_zero    = (opnd_q == '0);
  assign last        = (cnt == CNT_W'(WIDTH - 1));
  assign result_next = (mode_div && div_zero) ? '1 : lo_d;
  assign flag_next   = mode_div ? div_zero : (hi_d != '0);

  // Operand capture on load, one algorithm step per clock while enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      mode_div <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
    end else if (load) begin
      cnt      <= '0;
      mode_div <= is_div;
      hi_q     <= '0;
      lo_q     <= is_div ? a : b;
      opnd_q   <= is_div ? b : a;
    end else if (step_en) begin
      cnt  <= cnt + CNT_W'(1);
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Sequential ULA: single-cycle logic/arith ops, iterative MUL/DIV via ula_iter.
// Handshake: start is sampled only in IDLE; an accepted request produces exactly
// one done pulse (state DONE) with ula_result/carry/zero updated on the edge
// entering DONE. start seen in CALC or DONE is dropped, never queued.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] ula_result,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  logic [1:0]       state;
  logic             is_iter_op;
  logic             iter_load;
  logic             iter_last;
  logic [WIDTH-1:0] iter_result;
  logic             iter_flag;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  assign is_iter_op = (op == OP_MUL) || (op == OP_DIV);
  assign iter_load  = (state == ST_IDLE) && start && is_iter_op;
  assign busy       = (state == ST_CALC);
  assign done       = (state == ST_DONE);
  assign fsm_state  = state;

  ula_iter #(.WIDTH(WIDTH)) u_iter (
    .clock       (clock),
    .reset       (reset),
    .load        (iter_load),
    .is_div      (op == OP_DIV),
    .step_en     (state == ST_CALC),
    .a           (a),
    .b           (b),
    .last        (iter_last),
    .result_next (iter_result),
    .flag_next   (iter_flag)
  );

  // Single-cycle operations straight from the live inputs.
  always_comb begin
    sum_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      OP_SUB: begin
        sum_ext = {1'b0, a} - {1'b0, b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      default: alu_res = '0;
    endcase
  end

  // FSM plus result registers, which only load on the edge entering DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ula_result <= '0;
      carry      <= 1'b0;
      zero       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_iter_op) begin
              state <= ST_CALC;
            end else begin
              state      <= ST_DONE;
              ula_result <= alu_res;
              carry      <= alu_c;
              zero       <= (alu_res == '0);
            end
          end
        end
        ST_CALC: begin
          if (iter_last) begin
            state      <= ST_DONE;
            ula_result <= iter_result;
            carry      <= iter_flag;
            zero       <= (iter_result == '0);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
